// File: rtl/uart_rx_fifo_pkg.sv
// Shared sizing for the UART receive FIFO and its storage array.
// Macros are guarded so a project-wide define_uart.vh takes precedence when present.
`ifndef UART_NUMB_BIT_MAX
`define UART_NUMB_BIT_MAX 8
`endif
`ifndef UART_FIFO_DEPTH
`define UART_FIFO_DEPTH 16
`endif
`ifndef UART_FIFO_PTR_WD
`define UART_FIFO_PTR_WD 4
`endif
`ifndef UART_FIFO_DROP_WD
`define UART_FIFO_DROP_WD 8
`endif

package uart_rx_fifo_pkg;
  localparam int DATA_WD       = `UART_NUMB_BIT_MAX;
  localparam int FIFO_DEPTH    = `UART_FIFO_DEPTH;
  localparam int FIFO_PTR_WD   = `UART_FIFO_PTR_WD;
  localparam int FIFO_DROP_WD  = `UART_FIFO_DROP_WD;

  function automatic logic [FIFO_DROP_WD-1:0] sat_inc(input logic [FIFO_DROP_WD-1:0] val);
    return (val == '1) ? val : val + {{(FIFO_DROP_WD-1){1'b0}}, 1'b1};
  endfunction
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WD register array: synchronous write, asynchronous read.
// Contents are deliberately not reset; the owning FIFO masks stale data.
module uart_fifo_mem #(
  parameter int DEPTH   = 16,
  parameter int PTR_WD  = 4,
  parameter int DATA_WD = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [PTR_WD-1:0]  waddr_i,
  input  logic [DATA_WD-1:0] wdat_i,
  input  logic [PTR_WD-1:0]  raddr_i,
  output logic [DATA_WD-1:0] rdat_o
);

  logic [DATA_WD-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdat_i;
  end

  assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver: no backpressure on the byte
// pulse, so overflow is reported through a sticky flag and a saturating drop count.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int PTR_WD = FIFO_PTR_WD
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush_i,
  input  logic                    clr_ovf_i,
  input  logic [PTR_WD:0]         cfg_thr_i,
  input  logic                    val_i,
  input  logic [DATA_WD-1:0]      dat_i,
  output logic                    val_o,
  output logic [DATA_WD-1:0]      dat_o,
  input  logic                    rdy_i,
  output logic [PTR_WD:0]         cnt_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    irq_thr_o,
  output logic                    ovf_o,
  output logic [FIFO_DROP_WD-1:0] cnt_drop_o
);

  localparam logic [PTR_WD:0]   CNT_FULL = (PTR_WD+1)'(DEPTH);
  localparam logic [PTR_WD:0]   CNT_ONE  = (PTR_WD+1)'(1);
  localparam logic [PTR_WD-1:0] PTR_ONE  = PTR_WD'(1);

  logic [PTR_WD-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_WD:0]         cnt_q, cnt_d;
  logic                    irq_q, irq_d;
  logic                    ovf_q, ovf_d;
  logic [FIFO_DROP_WD-1:0] drop_q, drop_d;
  logic [DATA_WD-1:0]      mem_rdat;
  logic                    push, pop, drop, mem_we;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign val_o   = !empty_o;
  assign pop     = val_o && rdy_i;
  assign push    = val_i && (!full_o || pop);
  // A byte lost to flush is intentional, not an overflow.
  assign drop    = val_i && full_o && !pop && !flush_i;
  assign mem_we  = push && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_ovf_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d  = 1'b1;
      drop_d = sat_inc(drop_q);
    end
    // Registered from the next count so the flag lines up with cnt_o.
    irq_d = (cfg_thr_i != '0) && (cnt_d >= cfg_thr_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH   (DEPTH),
    .PTR_WD  (PTR_WD),
    .DATA_WD (DATA_WD)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdat_i  (dat_i),
    .raddr_i (rd_ptr_q),
    .rdat_o  (mem_rdat)
  );

  assign dat_o      = val_o ? mem_rdat : '0;
  assign cnt_o      = cnt_q;
  assign irq_thr_o  = irq_q;
  assign ovf_o      = ovf_q;
  assign cnt_drop_o = drop_q;

endmodule
